// File: rtl/pc_update_ctrl.sv
// pc_update_ctrl: sequences the PC-source mux and PC/EPC/cause write enables,
// including the exception entry: save EPC, fetch the vector byte, load PC.
module pc_update_ctrl #(
    parameter int MEM_LAT  = 3,
    parameter int VEC_BASE = 253,
    parameter int ADDR_W   = 32
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              req_valid_i,
    input  logic [2:0]        req_kind_i,
    input  logic              branch_taken_i,
    input  logic              exc_valid_i,
    input  logic [1:0]        exc_cause_i,
    output logic              req_ack_o,
    output logic              busy_o,
    output logic [2:0]        pcsource_sel_o,
    output logic              pc_write_o,
    output logic              epc_write_o,
    output logic              cause_write_o,
    output logic [1:0]        cause_out_o,
    output logic              vec_rd_o,
    output logic [ADDR_W-1:0] vec_addr_o,
    output logic              mdr_load_o,
    output logic              done_o,
    output logic              exc_lost_o
);
    localparam int CW = $clog2(MEM_LAT + 1);

    typedef enum logic [2:0] {IDLE, UPDATE, EXC_EPC, EXC_WAIT, EXC_LOAD, EXC_PC} state_t;

    state_t            state_q, state_d;
    logic [2:0]        kind_q, kind_d, sel_q, sel_d;
    logic              taken_q, taken_d, pend_q, pend_d;
    logic [1:0]        cause_q, cause_d, pcause_q, pcause_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              exc, in_exc, fetch_d, pcw_d;
    logic              pc_write_q, epc_write_q, cause_write_q, vec_rd_q, mdr_load_q, done_q, busy_q;
    logic [1:0]        cause_out_q;
    logic [ADDR_W-1:0] vec_addr_q;

    always_comb begin
        exc      = exc_valid_i && exc_cause_i != 2'd0;
        in_exc   = state_q inside {EXC_EPC, EXC_WAIT, EXC_LOAD, EXC_PC};
        state_d  = state_q;
        kind_d   = kind_q;
        taken_d  = taken_q;
        cause_d  = cause_q;
        pend_d   = pend_q;
        pcause_d = pcause_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (pend_q) begin
                    state_d = EXC_EPC;
                    cause_d = pcause_q;
                    pend_d  = 1'b0;
                end else if (exc) begin
                    state_d = EXC_EPC;
                    cause_d = exc_cause_i;
                end else if (req_valid_i) begin
                    state_d = UPDATE;
                    kind_d  = req_kind_i;
                    taken_d = branch_taken_i;
                end
            end
            UPDATE: begin
                state_d = IDLE;
                if (exc && !pend_q) begin
                    pend_d   = 1'b1;
                    pcause_d = exc_cause_i;
                end
            end
            EXC_EPC: begin
                state_d = EXC_WAIT;
                cnt_d   = CW'(MEM_LAT);
            end
            EXC_WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = EXC_LOAD;
            end
            EXC_LOAD: state_d = EXC_PC;
            default:  state_d = IDLE;
        endcase
        fetch_d = state_d inside {EXC_EPC, EXC_WAIT};
        pcw_d   = (state_d == UPDATE && kind_d < 3'd5 && (kind_d != 3'd1 || taken_d)) || state_d == EXC_PC;
        // Kinds 5..7 have no mux source, so the select keeps its last value.
        sel_d   = state_d == EXC_PC ? 3'd0 :
                  state_d != UPDATE ? sel_q :
                  (kind_d == 3'd0 || kind_d == 3'd3) ? 3'd1 :
                  kind_d == 3'd1 ? 3'd2 :
                  kind_d == 3'd2 ? 3'd3 :
                  kind_d == 3'd4 ? 3'd4 : sel_q;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= IDLE;
            kind_q        <= 3'd0;
            taken_q       <= 1'b0;
            cause_q       <= 2'd0;
            pend_q        <= 1'b0;
            pcause_q      <= 2'd0;
            cnt_q         <= '0;
            sel_q         <= 3'd1;
            pc_write_q    <= 1'b0;
            epc_write_q   <= 1'b0;
            cause_write_q <= 1'b0;
            cause_out_q   <= 2'd0;
            vec_rd_q      <= 1'b0;
            vec_addr_q    <= '0;
            mdr_load_q    <= 1'b0;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            kind_q        <= kind_d;
            taken_q       <= taken_d;
            cause_q       <= cause_d;
            pend_q        <= pend_d;
            pcause_q      <= pcause_d;
            cnt_q         <= cnt_d;
            sel_q         <= sel_d;
            pc_write_q    <= pcw_d;
            epc_write_q   <= state_d == EXC_EPC;
            cause_write_q <= state_d == EXC_EPC;
            cause_out_q   <= state_d == EXC_EPC ? cause_d : 2'd0;
            vec_rd_q      <= fetch_d;
            vec_addr_q    <= fetch_d ? ADDR_W'(VEC_BASE) + ADDR_W'(cause_d) - ADDR_W'(1) : '0;
            mdr_load_q    <= state_d == EXC_LOAD;
            done_q        <= state_d inside {UPDATE, EXC_PC};
            busy_q        <= state_d != IDLE;
        end
    end

    // Accept and drop decisions belong to the cycle in which they are made.
    assign req_ack_o      = !reset_i && state_q == IDLE && !pend_q && !exc && req_valid_i;
    assign exc_lost_o     = !reset_i && exc && (in_exc || (state_q == UPDATE && pend_q));
    assign busy_o         = busy_q;
    assign pcsource_sel_o = sel_q;
    assign pc_write_o     = pc_write_q && !reset_i;
    assign epc_write_o    = epc_write_q && !reset_i;
    assign cause_write_o  = cause_write_q && !reset_i;
    assign cause_out_o    = cause_out_q;
    assign vec_rd_o       = vec_rd_q && !reset_i;
    assign vec_addr_o     = vec_addr_q;
    assign mdr_load_o     = mdr_load_q && !reset_i;
    assign done_o         = done_q;
endmodule

// File: tb/tb_pc_update_ctrl.sv
// tb_pc_update_ctrl: directed stimulus against a cycle-scheduled model of the
// PC-update and exception-entry sequences, plus hand-computed spot checks.
module tb_pc_update_ctrl;
    localparam int ML = 3, VB = 253, AW = 32, NC = 1024;

    logic          clk = 1'b0, reset, req_valid, branch_taken, exc_valid;
    logic [2:0]    req_kind;
    logic [1:0]    exc_cause;
    logic          req_ack, busy, pc_write, epc_write, cause_write, vec_rd, mdr_load, done, exc_lost;
    logic [2:0]    pcsource_sel;
    logic [1:0]    cause_out;
    logic [AW-1:0] vec_addr;

    pc_update_ctrl #(.MEM_LAT(ML), .VEC_BASE(VB), .ADDR_W(AW)) dut (
        .clk_i(clk), .reset_i(reset), .req_valid_i(req_valid), .req_kind_i(req_kind),
        .branch_taken_i(branch_taken), .exc_valid_i(exc_valid), .exc_cause_i(exc_cause),
        .req_ack_o(req_ack), .busy_o(busy), .pcsource_sel_o(pcsource_sel), .pc_write_o(pc_write),
        .epc_write_o(epc_write), .cause_write_o(cause_write), .cause_out_o(cause_out),
        .vec_rd_o(vec_rd), .vec_addr_o(vec_addr), .mdr_load_o(mdr_load), .done_o(done),
        .exc_lost_o(exc_lost)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, cyc = 0;
    bit chk_en = 1'b0;
    int e_ack[NC], e_lost[NC], e_busy[NC], e_pcw[NC], e_epcw[NC], e_cw[NC], e_cout[NC];
    int e_vrd[NC], e_vaddr[NC], e_mdr[NC], e_done[NC], sel_set[NC];
    int sel_map[5] = '{1, 2, 3, 1, 4};
    int free_at = 0, upd_cyc = -1, pend = 0, pcause = 0, cur_sel = 1, exc_lo = -1, exc_hi = -2;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Exception accepted while idle in cycle c: every later effect is placed at its absolute cycle.
    function automatic void start_exc(int c, int k);
        for (int t = c + 1; t <= c + ML + 3; t++) e_busy[t] = 1;
        e_epcw[c+1] = 1; e_cw[c+1] = 1; e_cout[c+1] = k;
        for (int t = c + 1; t <= c + ML + 1; t++) begin
            e_vrd[t] = 1;
            e_vaddr[t] = VB + k - 1;
        end
        e_mdr[c+ML+2] = 1;
        e_pcw[c+ML+3] = 1; e_done[c+ML+3] = 1; sel_set[c+ML+3] = 0;
        exc_lo = c + 1; exc_hi = c + ML + 3; free_at = c + ML + 4; upd_cyc = -1;
    endfunction

    function automatic void start_upd(int c, int kind, int taken);
        e_busy[c+1] = 1; e_done[c+1] = 1;
        e_pcw[c+1] = (kind < 5 && (kind != 1 || taken != 0)) ? 1 : 0;
        if (kind < 5) sel_set[c+1] = sel_map[kind];
        upd_cyc = c + 1; free_at = c + 2;
    endfunction

    initial for (int i = 0; i < NC; i++) sel_set[i] = -1;

    always @(negedge clk) begin
        int c;
        c = cyc;
        if (c > NC - 20) begin
            $display("FAIL cycle_budget at cycle %0d: got over budget expected under %0d", c, NC - 20);
            $fatal(1);
        end
        if (reset) begin
            for (int t = c + 1; t < NC; t++) begin
                e_ack[t] = 0; e_lost[t] = 0; e_busy[t] = 0; e_pcw[t] = 0; e_epcw[t] = 0; e_cw[t] = 0;
                e_cout[t] = 0; e_vrd[t] = 0; e_vaddr[t] = 0; e_mdr[t] = 0; e_done[t] = 0; sel_set[t] = -1;
            end
            sel_set[c+1] = 1;
            e_pcw[c] = 0; e_epcw[c] = 0; e_cw[c] = 0; e_vrd[c] = 0; e_mdr[c] = 0;
            free_at = c + 1; pend = 0; upd_cyc = -1; exc_lo = -1; exc_hi = -2;
        end else begin
            bit ex;
            ex = exc_valid && exc_cause != 2'd0;
            if (c >= free_at) begin
                if (pend != 0) begin
                    start_exc(c, pcause);
                    pend = 0;
                end else if (ex) start_exc(c, int'(exc_cause));
                else if (req_valid) begin
                    e_ack[c] = 1;
                    start_upd(c, int'(req_kind), int'(branch_taken));
                end
            end else if (c == upd_cyc) begin
                if (ex && pend == 0) begin
                    pend = 1;
                    pcause = int'(exc_cause);
                end else if (ex) e_lost[c] = 1;
            end else if (ex && c >= exc_lo && c <= exc_hi) e_lost[c] = 1;
        end
        if (sel_set[c] >= 0) cur_sel = sel_set[c];
        if (chk_en) begin
            chk("ack", int'(req_ack), e_ack[c]);
            chk("exc_lost", int'(exc_lost), e_lost[c]);
            chk("busy", int'(busy), e_busy[c]);
            chk("pc_write", int'(pc_write), e_pcw[c]);
            chk("epc_write", int'(epc_write), e_epcw[c]);
            chk("cause_write", int'(cause_write), e_cw[c]);
            chk("cause_out", int'(cause_out), e_cout[c]);
            chk("vec_rd", int'(vec_rd), e_vrd[c]);
            chk("vec_addr", int'(vec_addr), e_vaddr[c]);
            chk("mdr_load", int'(mdr_load), e_mdr[c]);
            chk("done", int'(done), e_done[c]);
            chk("pcsource_sel", int'(pcsource_sel), cur_sel);
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(int kind, int taken, int exp_sel, int exp_pcw);
        int got;
        got = 0;
        nxt();
        req_valid = 1'b1; req_kind = 3'(kind); branch_taken = taken[0];
        for (int i = 0; i < 20 && got == 0; i++) begin
            @(negedge clk);
            if (req_ack) got = 1;
            else nxt();
        end
        chk("req_acked", got, 1);
        nxt();
        req_valid = 1'b0;
        @(negedge clk);
        chk("req_sel", int'(pcsource_sel), exp_sel);
        chk("req_pc_write", int'(pc_write), exp_pcw);
        chk("req_done", int'(done), 1);
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_kind = 3'd0; branch_taken = 1'b0;
        exc_valid = 1'b0; exc_cause = 2'd0;
        nxt(); nxt();
        reset = 1'b0; chk_en = 1'b1;
        @(negedge clk);
        chk("rst_sel", int'(pcsource_sel), 1);
        chk("rst_busy", int'(busy), 0);
        // Sequential update: ack at N, write at N+1, idle at N+2.
        nxt(); req_valid = 1'b1; req_kind = 3'd0;
        @(negedge clk); chk("t1_ack", int'(req_ack), 1);
        nxt(); req_valid = 1'b0;
        @(negedge clk);
        chk("t1_sel", int'(pcsource_sel), 1); chk("t1_pcw", int'(pc_write), 1); chk("t1_done", int'(done), 1);
        nxt(); @(negedge clk); chk("t1_busy", int'(busy), 0);
        // Kind table, branch taken/not-taken, unused kind holds the select.
        do_req(1, 1, 2, 1);
        do_req(1, 0, 2, 0);
        do_req(2, 0, 3, 1);
        do_req(3, 0, 1, 1);
        do_req(4, 0, 4, 1);
        do_req(5, 0, 4, 0);
        // Overflow exception entry.
        nxt(); exc_valid = 1'b1; exc_cause = 2'd2;
        @(negedge clk); chk("t3_busy0", int'(busy), 0);
        nxt(); exc_valid = 1'b0;
        @(negedge clk);
        chk("t3_epcw", int'(epc_write), 1); chk("t3_cw", int'(cause_write), 1);
        chk("t3_cause", int'(cause_out), 2); chk("t3_vaddr", int'(vec_addr), 254); chk("t3_vrd", int'(vec_rd), 1);
        nxt(); nxt(); nxt(); @(negedge clk);
        chk("t3_vrd_last", int'(vec_rd), 1); chk("t3_mdr_early", int'(mdr_load), 0);
        nxt(); @(negedge clk);
        chk("t3_mdr", int'(mdr_load), 1); chk("t3_vrd_off", int'(vec_rd), 0); chk("t3_vaddr0", int'(vec_addr), 0);
        nxt(); @(negedge clk);
        chk("t3_sel", int'(pcsource_sel), 0); chk("t3_pcw", int'(pc_write), 1); chk("t3_done", int'(done), 1);
        nxt(); @(negedge clk); chk("t3_idle", int'(busy), 0);
        // Same-cycle rte request and divide-by-zero: the exception goes first.
        nxt(); req_valid = 1'b1; req_kind = 3'd4; exc_valid = 1'b1; exc_cause = 2'd3;
        @(negedge clk); chk("t4_noack", int'(req_ack), 0);
        nxt(); exc_valid = 1'b0;
        @(negedge clk); chk("t4_vaddr", int'(vec_addr), 255);
        repeat (5) nxt();
        @(negedge clk); chk("t4_done", int'(done), 1); chk("t4_ack_busy", int'(req_ack), 0);
        nxt(); @(negedge clk); chk("t4_ack", int'(req_ack), 1);
        nxt(); req_valid = 1'b0;
        @(negedge clk); chk("t4_sel", int'(pcsource_sel), 4); chk("t4_pcw", int'(pc_write), 1);
        // Exception during UPDATE goes pending; one during EXC_WAIT is lost.
        nxt(); req_valid = 1'b1; req_kind = 3'd0;
        @(negedge clk); chk("t5_ack", int'(req_ack), 1);
        nxt(); req_valid = 1'b0; exc_valid = 1'b1; exc_cause = 2'd1;
        @(negedge clk); chk("t5_nolost", int'(exc_lost), 0);
        nxt(); exc_valid = 1'b0;
        @(negedge clk); chk("t5_idle", int'(busy), 0);
        nxt(); @(negedge clk);
        chk("t5_epcw", int'(epc_write), 1); chk("t5_vaddr", int'(vec_addr), 253);
        nxt(); exc_valid = 1'b1; exc_cause = 2'd2;
        @(negedge clk); chk("t5_lost", int'(exc_lost), 1);
        nxt(); exc_valid = 1'b0;
        repeat (3) nxt();
        @(negedge clk); chk("t5_done", int'(done), 1);
        nxt(); nxt(); @(negedge clk);
        chk("t5_no_reentry", int'(busy), 0); chk("t5_no_epcw", int'(epc_write), 0);
        // Cause 0 is not an exception.
        nxt(); exc_valid = 1'b1; exc_cause = 2'd0;
        nxt(); exc_valid = 1'b0;
        @(negedge clk); chk("cause0_busy", int'(busy), 0);
        // Reset during EXC_WAIT aborts the fetch.
        nxt(); exc_valid = 1'b1; exc_cause = 2'd3;
        nxt(); exc_valid = 1'b0;
        nxt(); reset = 1'b1;
        @(negedge clk); chk("t6_vrd_gated", int'(vec_rd), 0);
        nxt(); reset = 1'b0;
        @(negedge clk); chk("t6_busy", int'(busy), 0); chk("t6_sel", int'(pcsource_sel), 1);
        nxt(); nxt(); nxt(); @(negedge clk);
        chk("t6_mdr", int'(mdr_load), 0); chk("t6_pcw", int'(pc_write), 0);
        // Reset landing on the final PC load suppresses the write.
        nxt(); exc_valid = 1'b1; exc_cause = 2'd1;
        nxt(); exc_valid = 1'b0;
        repeat (5) nxt();
        reset = 1'b1;
        @(negedge clk); chk("t6b_pcw_gated", int'(pc_write), 0); chk("t6b_sel", int'(pcsource_sel), 0);
        nxt(); reset = 1'b0;
        @(negedge clk); chk("t6b_sel_rst", int'(pcsource_sel), 1); chk("t6b_busy", int'(busy), 0);
        do_req(3, 0, 1, 1);
        nxt(); nxt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
